// File: rtl/entity_scheduler_pkg.sv
// Shared types and constants for the game-tick scheduler: FSM state
// encoding, button bit positions and default timing parameters.
package entity_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLAYER = 3'd1,
    ST_DRAGON = 3'd2,
    ST_COLL   = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  localparam int DEF_FRAMES_PER_TICK = 8;
  localparam int DEF_TIMEOUT         = 255;

endpackage

// File: rtl/entity_scheduler_frame_divider.sv
// Divides frame_start pulses into game ticks and owns the START-edge pause toggle.
// tick_due_o is combinational so the scheduler can react on the next edge.
module entity_scheduler_frame_divider #(
  parameter int FRAMES_PER_TICK = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start_i,
  input  logic start_btn_i,
  input  logic game_over_i,
  output logic tick_due_o,
  output logic paused_o
);

  localparam logic [7:0] LAST = 8'(FRAMES_PER_TICK - 1);

  logic [7:0] count_q, count_d;
  logic       start_prev_q, start_prev_d;
  logic       paused_q, paused_d;
  logic       advance;

  // The paused value in force when the frame arrives decides whether it counts.
  assign advance    = frame_start_i && !paused_q && !game_over_i;
  assign tick_due_o = advance && (count_q == LAST);
  assign paused_o   = paused_q;

  always_comb begin
    count_d      = count_q;
    start_prev_d = start_prev_q;
    paused_d     = paused_q;
    if (advance) begin
      count_d = (count_q == LAST) ? 8'd0 : count_q + 8'd1;
    end
    if (frame_start_i) begin
      start_prev_d = start_btn_i;
      if (start_btn_i && !start_prev_q) begin
        paused_d = !paused_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= 8'd0;
      start_prev_q <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      count_q      <= count_d;
      start_prev_q <= start_prev_d;
      paused_q     <= paused_d;
    end
  end

endmodule

// File: rtl/entity_scheduler.sv
// Game-tick controller: sequences player, dragon and collision phases with
// req/done handshakes, a per-phase watchdog, then a one-cycle commit.
module entity_scheduler
  import entity_scheduler_pkg::*;
#(
  parameter int FRAMES_PER_TICK = DEF_FRAMES_PER_TICK,
  parameter int TIMEOUT         = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [7:0] btn_in,
  input  logic       game_over,
  output logic [7:0] btn_latched,
  output logic       tick,
  output logic       player_req,
  input  logic       player_done,
  output logic       dragon_req,
  input  logic       dragon_done,
  output logic       coll_req,
  input  logic       coll_done,
  output logic       commit,
  output logic       busy,
  output logic       paused,
  output logic       overrun,
  output logic       fault
);

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wdog_q, wdog_d;
  logic [7:0] btn_latched_q;
  logic       tick_q, overrun_q, fault_q;
  logic       tick_due, req_active, phase_done, wdog_expire, fault_set;

  entity_scheduler_frame_divider #(
    .FRAMES_PER_TICK(FRAMES_PER_TICK)
  ) u_divider (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start_i(frame_start),
    .start_btn_i  (btn_in[BTN_START]),
    .game_over_i  (game_over),
    .tick_due_o   (tick_due),
    .paused_o     (paused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wdog_q        <= 8'd0;
      btn_latched_q <= 8'd0;
      tick_q        <= 1'b0;
      overrun_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      tick_q    <= tick_due && (state_q == ST_IDLE);
      overrun_q <= overrun_q | (tick_due && (state_q != ST_IDLE));
      fault_q   <= fault_q | fault_set;
      if (tick_due && (state_q == ST_IDLE)) begin
        btn_latched_q <= btn_in;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_active = 1'b0;
    phase_done = 1'b0;
    case (state_q)
      ST_IDLE:   if (tick_due) state_d = ST_PLAYER;
      ST_PLAYER: begin req_active = 1'b1; phase_done = player_done; end
      ST_DRAGON: begin req_active = 1'b1; phase_done = dragon_done; end
      ST_COLL:   begin req_active = 1'b1; phase_done = coll_done;   end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // A done arriving on the expiry cycle wins; only a true timeout is a fault.
    wdog_expire = req_active && (wdog_q == WDOG_LAST);
    fault_set   = wdog_expire && !phase_done;
    if (req_active && (phase_done || wdog_expire)) begin
      case (state_q)
        ST_PLAYER: state_d = ST_DRAGON;
        ST_DRAGON: state_d = ST_COLL;
        default:   state_d = ST_COMMIT;
      endcase
    end
    if (state_d != state_q) begin
      wdog_d = 8'd0;
    end else if (req_active) begin
      wdog_d = wdog_q + 8'd1;
    end else begin
      wdog_d = wdog_q;
    end
  end

  always_comb begin
    player_req  = (state_q == ST_PLAYER);
    dragon_req  = (state_q == ST_DRAGON);
    coll_req    = (state_q == ST_COLL);
    commit      = (state_q == ST_COMMIT);
    busy        = (state_q != ST_IDLE);
    tick        = tick_q;
    btn_latched = btn_latched_q;
    overrun     = overrun_q;
    fault       = fault_q;
  end

endmodule

// File: tb/tb_entity_scheduler.sv
// Directed bench for entity_scheduler with FRAMES_PER_TICK=3 and TIMEOUT=10.
module tb_entity_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] btn_in = 8'h00;
  logic       game_over = 1'b0;
  logic [7:0] btn_latched;
  logic       tick, player_req, dragon_req, coll_req, commit, busy, paused, overrun, fault;
  logic       player_done = 1'b1;
  logic       dragon_done = 1'b1;
  logic       coll_done = 1'b1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  entity_scheduler #(.FRAMES_PER_TICK(3), .TIMEOUT(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .btn_in(btn_in),
    .game_over(game_over), .btn_latched(btn_latched), .tick(tick),
    .player_req(player_req), .player_done(player_done),
    .dragon_req(dragon_req), .dragon_done(dragon_done),
    .coll_req(coll_req), .coll_done(coll_done),
    .commit(commit), .busy(busy), .paused(paused), .overrun(overrun), .fault(fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"}, {tick, player_req, dragon_req, coll_req, commit, busy, overrun, fault}, 8'h00);
    chk({tag, "_paused"}, {7'd0, paused}, 8'h00);
    chk({tag, "_btn"}, btn_latched, 8'h00);
  endtask

  initial begin
    logic [7:0] exp_latch;
    logic       is_tick;

    // Reset state
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset");

    // Nine frames, ticks on the 3rd, 6th and 9th, zero-wait requesters
    exp_latch = 8'h00;
    for (int k = 0; k < 9; k++) begin
      is_tick = (k % 3 == 2);
      btn_in = (k == 2) ? 8'h84 : 8'h00;
      frame();
      btn_in = 8'h00;
      if (is_tick) exp_latch = (k == 2) ? 8'h84 : 8'h00;
      chk($sformatf("f%0d_tick", k), {7'd0, tick}, {7'd0, is_tick});
      chk($sformatf("f%0d_preq", k), {7'd0, player_req}, {7'd0, is_tick});
      chk($sformatf("f%0d_btn", k), btn_latched, exp_latch);
      step();
      chk($sformatf("f%0d_dreq", k), {7'd0, dragon_req}, {7'd0, is_tick});
      chk($sformatf("f%0d_tick_low", k), {7'd0, tick}, 8'h00);
      step();
      chk($sformatf("f%0d_creq", k), {7'd0, coll_req}, {7'd0, is_tick});
      step();
      chk($sformatf("f%0d_commit", k), {7'd0, commit}, {7'd0, is_tick});
      step();
      chk($sformatf("f%0d_idle", k), {7'd0, busy}, 8'h00);
      chk($sformatf("f%0d_btn_hold", k), btn_latched, exp_latch);
    end
    chk("run_flags", {6'd0, overrun, fault}, 8'h00);

    // Pause: START held across three frames toggles once
    do_reset();
    btn_in = 8'h10;
    for (int k = 0; k < 3; k++) begin
      frame();
      chk($sformatf("pause_hold%0d", k), {7'd0, paused}, 8'h01);
      chk($sformatf("pause_notick%0d", k), {6'd0, tick, busy}, 8'h00);
      step();
    end
    btn_in = 8'h00;
    frame();
    chk("pause_release", {7'd0, paused}, 8'h01);
    chk("pause_release_notick", {6'd0, tick, busy}, 8'h00);
    btn_in = 8'h10;
    frame();
    btn_in = 8'h00;
    chk("unpause", {7'd0, paused}, 8'h00);
    chk("unpause_notick", {6'd0, tick, busy}, 8'h00);

    // Watchdog: dragon_done stuck low, TIMEOUT=10
    do_reset();
    dragon_done = 1'b0;
    frame(); frame(); frame();
    chk("wd_tick", {7'd0, tick}, 8'h01);
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("wd_dreq%0d", k), {7'd0, dragon_req}, 8'h01);
      chk($sformatf("wd_nofault%0d", k), {7'd0, fault}, 8'h00);
    end
    step();
    chk("wd_abort", {5'd0, dragon_req, coll_req, fault}, 8'h03);
    step();
    chk("wd_commit", {7'd0, commit}, 8'h01);
    step();
    chk("wd_idle", {6'd0, busy, fault}, 8'h01);
    dragon_done = 1'b1;

    // Overrun: player stalls while three more frames make a tick due
    do_reset();
    player_done = 1'b0;
    frame(); frame(); frame();
    chk("ov_tick", {6'd0, tick, player_req}, 8'h03);
    frame();
    frame();
    chk("ov_not_yet", {7'd0, overrun}, 8'h00);
    frame();
    chk("ov_set", {6'd0, overrun, player_req}, 8'h03);
    chk("ov_no_tick", {7'd0, tick}, 8'h00);
    player_done = 1'b1;
    step();
    chk("ov_dragon", {6'd0, dragon_req, tick}, 8'h02);
    step(); step();
    chk("ov_commit", {7'd0, commit}, 8'h01);
    step();
    chk("ov_idle", {5'd0, busy, overrun, fault}, 8'h02);

    // Reset asserted while in DRAGON
    do_reset();
    dragon_done = 1'b0;
    frame(); frame(); frame();
    step();
    chk("rst_in_dragon", {7'd0, dragon_req}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    step();
    rst_n = 1'b1;
    dragon_done = 1'b1;
    frame(); frame(); frame();
    chk("rst_restart", {5'd0, tick, player_req, dragon_req}, 8'h06);
    step(); step(); step();
    chk("rst_commit", {6'd0, commit, fault}, 8'h02);
    step();

    // game_over freezes the counter; a tick in flight still commits
    game_over = 1'b1;
    frame(); frame(); frame(); frame();
    chk("go_frozen", {6'd0, tick, busy}, 8'h00);
    game_over = 1'b0;
    frame(); frame();
    chk("go_early", {7'd0, tick}, 8'h00);
    frame();
    chk("go_tick", {7'd0, tick}, 8'h01);
    game_over = 1'b1;
    step(); step(); step();
    chk("go_commit", {7'd0, commit}, 8'h01);
    game_over = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/entity_scheduler.md
# entity_scheduler

Frame-rate game-tick controller for the TinyTapeStation game core. It divides the per-frame pulse from the video timing into game ticks. On each tick it snapshots the controller buttons, then runs the player update, dragon update and collision check in a fixed order using req/done handshakes. It ends each tick with a one-cycle commit pulse to the render side. It also owns pause (START toggle), game-over freeze, overrun detection and a per-phase watchdog.

## Interface
Parameters:
- FRAMES_PER_TICK, default 8: frame_start pulses per game tick, range 1..255.
- TIMEOUT, default 255: maximum cycles to wait for one phase's done before the phase is aborted, range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low; one clock domain only.
- frame_start  in  1  single-cycle pulse, once per video frame.
- btn_in  in  8  raw buttons {A,B,select,start,up,down,left,right}, bit 7 = A.
- game_over  in  1  level from the player/dragon logic; freezes ticking.
- btn_latched  out  8  button snapshot taken at the last tick.
- tick  out  1  one-cycle pulse at tick start.
- player_req / player_done  out/in  1  player-update handshake.
- dragon_req / dragon_done  out/in  1  dragon-update handshake.
- coll_req / coll_done  out/in  1  collision-check handshake.
- commit  out  1  one-cycle pulse; downstream latches new entity state.
- busy  out  1  high in every state except IDLE.
- paused  out  1  pause flag.
- overrun  out  1  sticky; a tick fell due while busy.
- fault  out  1  sticky; a phase watchdog expired.

## Operation
- Reset (rst_n low): every output, including both sticky flags, is 0. Frame counter is 0, state is IDLE, watchdog is 0, and the stored previous-START value is 0.
- Frame counter (8 bit):
  - Advances only on frame_start with paused=0 and game_over=0.
  - At FRAMES_PER_TICK-1 it wraps to 0 and a tick falls due.
  - With FRAMES_PER_TICK=1, every eligible frame_start is a tick.
- Pause:
  - On every frame_start, regardless of game_over, sample btn_in[4].
  - If the sample is 1 and the previous sample was 0, toggle paused.
  - Pausing does not abort a tick already in progress.
- Tick due in IDLE: assert tick, btn_latched <= btn_in, go to PLAYER.
- Tick due outside IDLE: set overrun. The tick is dropped and the counter still wraps.
- States:
  - IDLE: wait for a due tick.
  - PLAYER: player_req=1. Go to DRAGON on player_done or on watchdog expiry.
  - DRAGON: dragon_req=1. Go to COLL on dragon_done or on watchdog expiry.
  - COLL: coll_req=1. Go to COMMIT on coll_done or on watchdog expiry.
  - COMMIT: commit=1 for one cycle, then go to IDLE.
- Handshake:
  - req is registered and goes high the first cycle of its state.
  - It stays high until done is sampled high.
  - It is low the cycle after done, in the next state.
  - done is ignored when the matching req is low.
  - Only one req is high at any time.
- Watchdog:
  - Cleared on every state entry; increments each cycle while a req is high.
  - Reaching TIMEOUT sets fault and forces the state advance. The aborted req drops.
- game_over high: no new ticks. A tick in progress runs to COMMIT.
- rst_n low mid-tick: immediate return to the reset values; no commit.

## Timing
- Cycle t: frame_start causes a tick.
- t+1: tick=1, btn_latched updated, player_req=1.
- Zero-wait requesters (done high the first cycle req is high) complete a tick in 4 cycles after t: PLAYER, DRAGON, COLL, COMMIT at t+1..t+4. busy falls at t+5.
- Watchdog abort: the state leaves after TIMEOUT cycles with req high.
- overrun and fault set on the cycle after the causing event. Both clear only on reset.

## Structure
- Shared package: state encoding (IDLE, PLAYER, DRAGON, COLL, COMMIT), btn_in bit-index constants (A=7 … RIGHT=0), default FRAMES_PER_TICK and TIMEOUT.
- One natural sub-module, frame_divider: the frame counter plus START edge detection and the pause toggle. Its outputs are tick_due and paused.
- The sequencing FSM and watchdog stay in entity_scheduler.

## Test plan
- FRAMES_PER_TICK=3, all done tied high, 9 frame_start pulses → exactly 3 tick pulses, on the 3rd, 6th and 9th frames. Each is followed by player_req, dragon_req, coll_req, commit on consecutive cycles.
- btn_in=8'h84 at the tick frame, then btn_in=0 → btn_latched holds 8'h84 until the next tick.
- START held high across 3 frames → paused=1 after the 1st only. Release then press again → paused=0. No ticks while paused.
- dragon_done held low, TIMEOUT=10 → dragon_req high for 10 cycles, fault=1, coll_req follows, commit still pulses.
- player_done delayed 40 frames' worth of cycles with FRAMES_PER_TICK=1 → overrun=1, with no second tick pulse until IDLE.
- rst_n pulsed low while in DRAGON → all outputs 0 immediately. The next tick starts cleanly from PLAYER.
